// File: rtl/global_avg_pool_16ch_pkg.sv
// Shared definitions for the 16-channel global average pooling stage:
// FP32 field layout, constants, lane selection and the FP32 arithmetic
// helpers used by every channel. Build option: GAP_SCALE_EN (enables the
// FP32 multiply used to turn per-channel sums into means).
package global_avg_pool_16ch_pkg;

    localparam int FP_W      = 32;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MAN_W  = 23;
    localparam int FP_BIAS   = 127;
    localparam int GAP_LANES = 16;

    localparam logic [FP_W-1:0] FP_POS_ZERO     = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_QNAN         = 32'h7FC0_0000;
    // 1/(44*44) = 1/1936 for the default frame size
    localparam logic [FP_W-1:0] GAP_RECIP_44X44 = 32'h3A07_67AB;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_FIN   = 1'b1
    } gap_state_e;

    // Channel k of a packed 16-lane FP32 bus
    function automatic logic [FP_W-1:0] lane_sel(input logic [GAP_LANES*FP_W-1:0] bus,
                                                  input int unsigned k);
        return bus[k*FP_W +: FP_W];
    endfunction

    // Round a normalised 27-bit mantissa (hidden bit at [26], guard/round/sticky
    // at [2:0]) to nearest-even and pack; underflow flushes to signed zero.
    function automatic logic [FP_W-1:0] fp32_round_pack(input logic sgn,
                                                         input logic signed [10:0] e,
                                                         input logic [26:0] m);
        logic               rnd;
        logic [24:0]        m25;
        logic signed [10:0] e2;
        logic [FP_W-1:0]    res;
        rnd = m[2] & (m[3] | m[1] | m[0]);
        m25 = {1'b0, m[26:3]} + {24'd0, rnd};
        e2  = e;
        if (m25[24]) begin
            m25 = m25 >> 1;
            e2  = e + 11'sd1;
        end
        if (e2 >= 11'sd255)
            res = {sgn, 8'hFF, 23'd0};
        else if (e2 <= 11'sd0)
            res = {sgn, 31'd0};
        else
            res = {sgn, e2[7:0], m25[22:0]};
        return res;
    endfunction

    // FP32 add, RNE, denormal inputs/outputs flushed to zero
    function automatic logic [FP_W-1:0] fp32_add(input logic [FP_W-1:0] a,
                                                  input logic [FP_W-1:0] b);
        logic               sa, sb, sx, sy;
        logic [7:0]         ea, eb, ex, ey, d;
        logic [22:0]        fa, fb;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [26:0]        mx, my, my_sh, m_norm;
        logic [27:0]        msum;
        logic [4:0]         lz;
        logic               found;
        logic signed [10:0] e_res;
        logic [FP_W-1:0]    res;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        res = FP_POS_ZERO;
        if (a_nan || b_nan) begin
            res = FP_QNAN;
        end else if (a_inf && b_inf) begin
            res = (sa == sb) ? a : FP_QNAN;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if (a_zero && b_zero) begin
            res = {sa & sb, 31'd0};
        end else if (a_zero) begin
            res = b;
        end else if (b_zero) begin
            res = a;
        end else begin
            // x is the operand of larger magnitude
            if ({ea, fa} >= {eb, fb}) begin
                sx = sa; ex = ea; mx = {1'b1, fa, 3'b000};
                sy = sb; ey = eb; my = {1'b1, fb, 3'b000};
            end else begin
                sx = sb; ex = eb; mx = {1'b1, fb, 3'b000};
                sy = sa; ey = ea; my = {1'b1, fa, 3'b000};
            end
            d = ex - ey;
            if (d >= 8'd27) begin
                my_sh = 27'd1;
            end else begin
                my_sh    = my >> d;
                my_sh[0] = my_sh[0] | (|(my & ((27'd1 << d) - 27'd1)));
            end
            if (sx == sy) begin
                msum  = {1'b0, mx} + {1'b0, my_sh};
                e_res = $signed({3'b000, ex});
                if (msum[27]) begin
                    m_norm = {msum[27:2], msum[1] | msum[0]};
                    e_res  = e_res + 11'sd1;
                end else begin
                    m_norm = msum[26:0];
                end
                res = fp32_round_pack(sx, e_res, m_norm);
            end else begin
                m_norm = mx - my_sh;
                if (m_norm == 27'd0) begin
                    res = FP_POS_ZERO;
                end else begin
                    lz    = 5'd0;
                    found = 1'b0;
                    for (int i = 26; i >= 0; i--) begin
                        if (!found) begin
                            if (m_norm[i]) found = 1'b1;
                            else           lz = lz + 5'd1;
                        end
                    end
                    m_norm = m_norm << lz;
                    e_res  = $signed({3'b000, ex}) - $signed({6'd0, lz});
                    res    = fp32_round_pack(sx, e_res, m_norm);
                end
            end
        end
        return res;
    endfunction

`ifdef GAP_SCALE_EN
    // FP32 multiply, RNE, denormals flushed to zero
    function automatic logic [FP_W-1:0] fp32_mul(input logic [FP_W-1:0] a,
                                                  input logic [FP_W-1:0] b);
        logic               sgn;
        logic [7:0]         ea, eb;
        logic [22:0]        fa, fb;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0]        p;
        logic [26:0]        m;
        logic signed [10:0] e;
        logic [FP_W-1:0]    res;
        sgn = a[31] ^ b[31];
        ea = a[30:23]; fa = a[22:0];
        eb = b[30:23]; fb = b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = FP_QNAN;
        end else if (a_inf || b_inf) begin
            res = {sgn, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            res = {sgn, 31'd0};
        end else begin
            p = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
            e = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
            if (p[47]) begin
                m = {p[47:22], |p[21:0]};
                e = e + 11'sd1;
            end else begin
                m = {p[46:21], |p[20:0]};
            end
            res = fp32_round_pack(sgn, e, m);
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/global_avg_pool_16ch_channel.sv
// One channel of the pooling stage (module gap_channel_acc): running FP32
// accumulator, end-of-frame sum register and output register. With
// GAP_SCALE_EN defined the output register takes sum*RECIP, otherwise the
// raw sum; the output register stage exists in both builds.
module gap_channel_acc
    import global_avg_pool_16ch_pkg::*;
#(
    parameter logic [31:0] RECIP = GAP_RECIP_44X44
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        last_i,
    input  logic        fin_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    logic [31:0] acc_q;
    logic [31:0] sum_q;
    logic [31:0] out_q;
    logic [31:0] add_d;
    logic [31:0] scaled_d;

    assign add_d = fp32_add(acc_q, data_i);

`ifdef GAP_SCALE_EN
    assign scaled_d = fp32_mul(sum_q, RECIP);
`else
    logic unused_recip;
    assign unused_recip = ^RECIP;
    assign scaled_d     = sum_q;
`endif

    // Accumulate valid pixels; on the last pixel move the total to sum and restart from +0
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= FP_POS_ZERO;
            sum_q <= FP_POS_ZERO;
            out_q <= FP_POS_ZERO;
        end else begin
            if (valid_i) begin
                if (last_i) begin
                    sum_q <= add_d;
                    acc_q <= FP_POS_ZERO;
                end else begin
                    acc_q <= add_d;
                end
            end
            if (fin_i)
                out_q <= scaled_d;
        end
    end

    assign data_o = out_q;

endmodule

// File: rtl/global_avg_pool_16ch.sv
// Global average pooling over a 16-channel FP32 pixel stream. Counts pixels
// of an IMG_WIDHT x IMG_HEIGHT frame, flags the last one, and emits one
// 16-lane result with a single-cycle Valid_Out two cycles after the last
// pixel. Build option: GAP_SCALE_EN selects mean (sum*RECIP) over raw sum.
module global_avg_pool_16ch
    import global_avg_pool_16ch_pkg::*;
#(
    parameter int          DATA_WIDHT = 32,
    parameter int          IMG_WIDHT  = 44,
    parameter int          IMG_HEIGHT = 44,
    parameter logic [31:0] RECIP      = GAP_RECIP_44X44
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Valid_In,
    input  logic [DATA_WIDHT*16-1:0] Data_In,
    output logic [DATA_WIDHT*16-1:0] Data_Out,
    output logic                     Valid_Out
);

    localparam int N_PIX = IMG_WIDHT * IMG_HEIGHT;
    localparam int PIX_W = $clog2(N_PIX);

    logic [PIX_W-1:0] pix_cnt_q;
    logic [PIX_W-1:0] pix_cnt_d;
    gap_state_e       state_q;
    logic             valid_out_q;
    logic             last_pix;
    logic             fin;
    logic [31:0]      lane_out [GAP_LANES];

    assign last_pix = (pix_cnt_q == PIX_W'(N_PIX - 1));
    assign fin      = (state_q == ST_FIN);

    // Next pixel index: wraps to 0 after the last pixel of a frame
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (Valid_In)
            pix_cnt_d = last_pix ? '0 : pix_cnt_q + PIX_W'(1);
    end

    // Control FSM: FIN lasts one cycle after the last pixel, then Valid_Out pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            pix_cnt_q   <= '0;
            valid_out_q <= 1'b0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            valid_out_q <= fin;
            state_q     <= (Valid_In && last_pix) ? ST_FIN : ST_ACCUM;
        end
    end

    for (genvar gi = 0; gi < GAP_LANES; gi++) begin : g_ch
        gap_channel_acc #(
            .RECIP (RECIP)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .valid_i (Valid_In),
            .last_i  (last_pix),
            .fin_i   (fin),
            .data_i  (lane_sel(Data_In, gi)),
            .data_o  (lane_out[gi])
        );
        assign Data_Out[gi*DATA_WIDHT +: DATA_WIDHT] = lane_out[gi];
    end

    assign Valid_Out = valid_out_q;

endmodule

// File: tb/tb_global_avg_pool_16ch.sv
// Directed bench for global_avg_pool_16ch: table of full frames plus
// hand-written reset sequences and an Inf case. Expected results follow the
// build: raw sums by default, means when GAP_SCALE_EN is defined.
module tb_global_avg_pool_16ch;

    localparam int NPIX = 1936;
`ifdef GAP_SCALE_EN
    localparam int  TOL   = 2;
    localparam real SCALE = 1.0 / 1936.0;
`else
    localparam int  TOL   = 0;
    localparam real SCALE = 1.0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         Valid_In;
    logic [511:0] Data_In;
    logic [511:0] Data_Out;
    logic         Valid_Out;

    int checks   = 0;
    int failures = 0;
    int ncyc     = 0;

    int           exp_cyc_q[$];
    logic [511:0] exp_val_q[$];
    int           got_cyc_q[$];
    logic [511:0] got_val_q[$];

    typedef struct {
        logic [511:0] din;
        bit           gaps;
        logic [511:0] expv;
    } frame_vec_t;

    frame_vec_t tbl [4];

    global_avg_pool_16ch dut (
        .clk       (clk),
        .rst       (rst),
        .Valid_In  (Valid_In),
        .Data_In   (Data_In),
        .Data_Out  (Data_Out),
        .Valid_Out (Valid_Out)
    );

    always #5 clk = ~clk;

    // Cycle counter and capture of every Valid_Out cycle
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (Valid_Out) begin
            got_cyc_q.push_back(ncyc);
            got_val_q.push_back(Data_Out);
        end
    end

    // Exact FP32 encoding of a normal real value (truncating)
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] dbits;
        logic [10:0] e;
        dbits = $realtobits(r);
        e     = dbits[62:52] - 11'd896;
        if (r == 0.0) return 32'h0;
        return {dbits[63], e[7:0], dbits[51:29]};
    endfunction

    function automatic bit close(input logic [31:0] a, input logic [31:0] b);
        int da, db, diff;
        if (a === b) return 1'b1;
        if (a[31] !== b[31]) return 1'b0;
        da   = int'({1'b0, a[30:0]});
        db   = int'({1'b0, b[30:0]});
        diff = (da > db) ? da - db : db - da;
        return diff <= TOL;
    endfunction

    task automatic drive_frame(input logic [511:0] d, input bit gaps, input int n_pix,
                               input int sp_idx, input logic [511:0] sp_d,
                               input bit expect_pulse, input logic [511:0] expv);
        for (int i = 0; i < n_pix; i++) begin
            @(posedge clk); #1;
            Valid_In = 1'b1;
            Data_In  = (i == sp_idx) ? sp_d : d;
            if (i == n_pix - 1 && expect_pulse) begin
                exp_cyc_q.push_back(ncyc + 1);
                exp_val_q.push_back(expv);
            end
            if (gaps && i != n_pix - 1) begin
                @(posedge clk); #1;
                Valid_In = 1'b0;
                Data_In  = {16{$urandom}};
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            Valid_In = 1'b0;
            Data_In  = {16{$urandom}};
        end
    endtask

    task automatic check_pulses(input string tag);
        int n;
        checks++;
        if (got_cyc_q.size() != exp_cyc_q.size()) begin
            failures++;
            $display("FAIL %s pulse_count got=%0d want=%0d", tag, got_cyc_q.size(), exp_cyc_q.size());
        end
        n = (got_cyc_q.size() < exp_cyc_q.size()) ? got_cyc_q.size() : exp_cyc_q.size();
        for (int p = 0; p < n; p++) begin
            checks++;
            if (got_cyc_q[p] != exp_cyc_q[p] + 2) begin
                failures++;
                $display("FAIL %s latency pulse=%0d got_cycle=%0d want_cycle=%0d",
                         tag, p, got_cyc_q[p], exp_cyc_q[p] + 2);
            end
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (!close(got_val_q[p][k*32 +: 32], exp_val_q[p][k*32 +: 32])) begin
                    failures++;
                    $display("FAIL %s pulse=%0d lane=%0d got=%08h want=%08h", tag, p, k,
                             got_val_q[p][k*32 +: 32], exp_val_q[p][k*32 +: 32]);
                end
            end
        end
        $display("%s: %0d pulse(s) checked", tag, n);
        got_cyc_q.delete(); got_val_q.delete();
        exp_cyc_q.delete(); exp_val_q.delete();
    endtask

    task automatic check_zero_out(input string tag);
        @(negedge clk);
        checks++;
        if (Valid_Out !== 1'b0 || Data_Out !== 512'd0) begin
            failures++;
            $display("FAIL %s got valid=%b data=%h want valid=0 data=0", tag, Valid_Out, Data_Out);
        end else begin
            $display("%s: outputs zero", tag);
        end
    endtask

    initial begin
        logic [511:0] ones, twos, threes, halves, negs, inf_pix, inf_exp, tmp;
        real vals [4];

        // Frame table: lane value per entry, expected = value * NPIX * SCALE
        for (int k = 0; k < 16; k++) begin
            ones[k*32 +: 32]   = r2f(1.0);
            twos[k*32 +: 32]   = r2f(2.0);
            threes[k*32 +: 32] = r2f(3.0);
            halves[k*32 +: 32] = r2f(0.5);
            negs[k*32 +: 32]   = r2f(-real'(k + 1));
        end
        tbl[0].din = ones;   tbl[0].gaps = 1'b0;
        tbl[1].din = negs;   tbl[1].gaps = 1'b1;
        tbl[2].din = twos;   tbl[2].gaps = 1'b0;
        tbl[3].din = halves; tbl[3].gaps = 1'b0;
        for (int k = 0; k < 16; k++) begin
            vals[0] = 1.0; vals[1] = -real'(k + 1); vals[2] = 2.0; vals[3] = 0.5;
            for (int i = 0; i < 4; i++) begin
                tmp = tbl[i].expv;
                tmp[k*32 +: 32] = r2f(vals[i] * real'(NPIX) * SCALE);
                tbl[i].expv = tmp;
            end
        end

        rst = 1'b1; Valid_In = 1'b0; Data_In = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_zero_out("reset_state");
        idle(3);
        check_zero_out("idle_after_reset");

        // Table frames run back to back (entry 1 with gaps, no idle between frames)
        for (int i = 0; i < 4; i++)
            drive_frame(tbl[i].din, tbl[i].gaps, NPIX, -1, '0, 1'b1, tbl[i].expv);
        idle(6);
        checks++;
        if (got_cyc_q.size() < 4 || got_cyc_q[3] - got_cyc_q[2] != NPIX) begin
            failures++;
            $display("FAIL back_to_back_spacing got=%0d want=%0d",
                     (got_cyc_q.size() < 4) ? -1 : got_cyc_q[3] - got_cyc_q[2], NPIX);
        end
        check_pulses("table_frames");

        // Reset after 1000 pixels of 3.0; the pixel coinciding with rst is dropped
        drive_frame(threes, 1'b0, 1000, -1, '0, 1'b0, '0);
        @(posedge clk); #1;
        rst = 1'b1; Valid_In = 1'b1; Data_In = threes;
        @(posedge clk); #1;
        rst = 1'b0; Valid_In = 1'b0;
        check_zero_out("rst_mid_frame");
        drive_frame(ones, 1'b0, NPIX, -1, '0, 1'b1, tbl[0].expv);
        idle(6);
        check_pulses("after_mid_frame_rst");

        // Reset in the cycle between the last pixel and Valid_Out cancels the pulse
        drive_frame(twos, 1'b0, NPIX, -1, '0, 1'b0, '0);
        @(posedge clk); #1;
        rst = 1'b1; Valid_In = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero_out("rst_before_pulse");
        idle(6);
        check_pulses("rst_before_pulse_no_pulse");

        // One +Inf pixel in lane 5
        inf_pix = ones;
        inf_pix[5*32 +: 32] = 32'h7F80_0000;
        inf_exp = tbl[0].expv;
        inf_exp[5*32 +: 32] = 32'h7F80_0000;
        drive_frame(ones, 1'b0, NPIX, 700, inf_pix, 1'b1, inf_exp);
        idle(6);
        check_pulses("inf_lane5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
